seq_multiplier: RTL and testbench

Sequential signed shift-add multiplier that consumes the two operand register outputs of the expression datapath and produces a product for loading into the result register. It is started by a one-cycle `start` pulse and needs exactly WIDTH cycles of iteration. It reports completion with a one-cycle `done` pulse, which the controller uses directly as the load enable of the downstream register.

---
 rtl/expr_pkg.sv | 23 ++
 rtl/mul_narrow.sv | 44 ++++
 rtl/seq_multiplier.sv | 133 +++++++++++++
 tb/tb_seq_multiplier.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared definitions for the expression datapath: default width, multiplier
// state encoding and signed saturation limits.
package expr_pkg;

    localparam int MUL_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // Largest positive two's-complement value in w bits (low w bits are meaningful).
    function automatic logic [63:0] sat_max_f(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value in w bits (low w bits are meaningful).
    function automatic logic [63:0] sat_min_f(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/mul_narrow.sv
// Combinational narrowing of a 2*WIDTH signed product to WIDTH bits.
// Optional macro MUL_SAT_EN selects saturation instead of wrap-around.
module mul_narrow
    import expr_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   result,
    output logic               ovf
);

    localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max_f(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min_f(WIDTH));

    logic [WIDTH:0] upper_s;
    logic           ovf_s;

    // The product fits iff the top WIDTH+1 bits are a pure sign extension.
    always_comb begin
        upper_s = prod[2*WIDTH-1:WIDTH-1];
        ovf_s   = !((&upper_s) || (~|upper_s));
    end

    // Select the narrowed value: wrap, or clamp toward the true sign.
    always_comb begin
        result = prod[WIDTH-1:0];
`ifdef MUL_SAT_EN
        if (ovf_s) begin
            result = prod[2*WIDTH-1] ? SMIN : SMAX;
        end else begin
            result = prod[WIDTH-1:0];
        end
`else
        if (ovf_s) begin
            result = prod[WIDTH-1:0];
        end else begin
            result = prod[WIDTH-1:0];
        end
`endif
        ovf = ovf_s;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential signed shift-add multiplier: WIDTH iterations, one-cycle done pulse.
// Optional macro MUL_SAT_EN (in mul_narrow) saturates overflowing products.
module seq_multiplier
    import expr_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int                 CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);

    mul_state_e           state_r, state_s;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mplr_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CW-1:0]        cnt_r;
    logic                 sign_r;
    logic                 busy_r, done_r, ovf_r;
    logic [WIDTH-1:0]     result_r;

    logic                 accept_s, last_step_s;
    logic [WIDTH-1:0]     a_mag_s, b_mag_s;
    logic [2*WIDTH-1:0]   addend_s, acc_sum_s, prod_s;
    logic [WIDTH-1:0]     narrow_res_s;
    logic                 narrow_ovf_s;

    // Operand magnitudes; the most negative value maps onto 2^(WIDTH-1) unsigned.
    always_comb begin
        a_mag_s = a[WIDTH-1] ? (~a + ONE_W) : a;
        b_mag_s = b[WIDTH-1] ? (~b + ONE_W) : b;
    end

    // One shift-add step plus sign application for the final step.
    always_comb begin
        accept_s    = start && (state_r != ST_RUN);
        last_step_s = (state_r == ST_RUN) && (cnt_r == LAST_CNT);
        addend_s    = mplr_r[0] ? mcand_r : {(2*WIDTH){1'b0}};
        acc_sum_s   = acc_r + addend_s;
        prod_s      = sign_r ? (~acc_sum_s + ONE_2W) : acc_sum_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_RUN;
                else          state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_r == LAST_CNT) state_s = ST_DONE;
                else                   state_s = ST_RUN;
            end
            ST_DONE: begin
                if (accept_s) state_s = ST_RUN;
                else          state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= state_s;
    end

    // Iteration datapath: load on accept, shift-add while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_r <= {(2*WIDTH){1'b0}};
            mplr_r  <= {WIDTH{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            cnt_r   <= {CW{1'b0}};
            sign_r  <= 1'b0;
        end else if (accept_s) begin
            mcand_r <= {{WIDTH{1'b0}}, a_mag_s};
            mplr_r  <= b_mag_s;
            acc_r   <= {(2*WIDTH){1'b0}};
            cnt_r   <= {CW{1'b0}};
            sign_r  <= a[WIDTH-1] ^ b[WIDTH-1];
        end else if (state_r == ST_RUN) begin
            acc_r   <= acc_sum_s;
            mcand_r <= mcand_r << 1;
            mplr_r  <= mplr_r >> 1;
            cnt_r   <= cnt_r + CNT_ONE;
        end else begin
            acc_r   <= acc_r;
        end
    end

    mul_narrow #(.WIDTH(WIDTH)) u_narrow (
        .prod   (prod_s),
        .result (narrow_res_s),
        .ovf    (narrow_ovf_s)
    );

    // Registered outputs; result/ovf only change when DONE is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= last_step_s;
            if (last_step_s) begin
                result_r <= narrow_res_s;
                ovf_r    <= narrow_ovf_s;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table plus timing/corner sequences.
module tb_seq_multiplier;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, ovf;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res_wrap;
        logic [W-1:0] res_sat;
        logic         ovf;
    } vec_t;

    exp_t sb_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name,
                     $signed(act), act, $signed(req), req);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("result", 32'($signed(result)), 32'($signed(e.res)));
                check("ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] er, input logic eo,
                          input bit poke_run, input bit chk_hold,
                          input logic [W-1:0] hold_v, output int lat);
        exp_t e;
        e.res = er;
        e.ovf = eo;
        start = 1'b1;
        a     = ia;
        b     = ib;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        check("no_done_after_start", 32'(done), 32'd0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            if (chk_hold && i == 8) check("result_hold", 32'(result), 32'(hold_v));
            if (poke_run && i == 5) begin
                start = 1'b1;
                a     = 16'h1234;
                b     = 16'h0042;
            end
            if (poke_run && i == 6) start = 1'b0;
        end
        check("latency", 32'(lat), 32'(W));
        check("busy_in_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vecs[14];
        int           lat;
        int           prev;
        logic [W-1:0] er;

        vecs[0]  = '{16'd7,      16'hFFFD, 16'hFFEB, 16'hFFEB, 1'b0};
        vecs[1]  = '{16'h8000,   16'hFFFF, 16'h8000, 16'h7FFF, 1'b1};
        vecs[2]  = '{16'd300,    16'hFF38, 16'd5536, 16'h8000, 1'b1};
        vecs[3]  = '{16'hFFFB,   16'hFFFB, 16'd25,   16'd25,   1'b0};
        vecs[4]  = '{16'd0,      16'h8000, 16'd0,    16'd0,    1'b0};
        vecs[5]  = '{16'h7FFF,   16'h7FFF, 16'd1,    16'h7FFF, 1'b1};
        vecs[6]  = '{16'h8000,   16'd1,    16'h8000, 16'h8000, 1'b0};
        vecs[7]  = '{16'd181,    16'd181,  16'd32761,16'd32761,1'b0};
        vecs[8]  = '{16'd128,    16'd256,  16'h8000, 16'h7FFF, 1'b1};
        vecs[9]  = '{16'hFF80,   16'd256,  16'h8000, 16'h8000, 1'b0};
        vecs[10] = '{16'hFFFF,   16'hFFFF, 16'd1,    16'd1,    1'b0};
        vecs[11] = '{16'd1234,   16'hFFFF, 16'hFB2E, 16'hFB2E, 1'b0};
        vecs[12] = '{16'h8000,   16'h8000, 16'd0,    16'h7FFF, 1'b1};
        vecs[13] = '{16'd255,    16'hFF7F, 16'h7F81, 16'h8000, 1'b1};

        rst   = 1'b0;
        start = 1'b0;
        a     = 16'd0;
        b     = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_done",   32'(done),   32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_ovf",    32'(ovf),    32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
`ifdef MUL_SAT_EN
            er = vecs[i].res_sat;
`else
            er = vecs[i].res_wrap;
`endif
            run_op(vecs[i].a, vecs[i].b, er, vecs[i].ovf, 1'b0, 1'b0, 16'd0, lat);
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
        end

        // Start pulse during RUN must be ignored.
        prev = done_cnt;
        run_op(16'd7, 16'hFFFD, 16'hFFEB, 1'b0, 1'b1, 1'b0, 16'd0, lat);
        repeat (20) @(negedge clk);
        check("ignored_start_done_count", 32'(done_cnt), 32'(prev + 1));

        // Back-to-back: second start issued in the DONE cycle.
`ifdef MUL_SAT_EN
        er = 16'h8000;
`else
        er = 16'd5536;
`endif
        run_op(16'd300, 16'hFF38, er, 1'b1, 1'b0, 1'b0, 16'd0, lat);
        run_op(16'hFFFB, 16'hFFFB, 16'd25, 1'b0, 1'b0, 1'b0, 16'd0, lat);
        @(negedge clk);
        check("b2b_done_one_cycle", 32'(done), 32'd0);

        // Zero operand, then hold across idle cycles and a later start.
        run_op(16'd0, 16'h8000, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, lat);
        repeat (5) @(negedge clk);
        check("zero_hold_result", 32'(result), 32'd0);
        check("zero_hold_ovf",    32'(ovf),    32'd0);
        run_op(16'd7, 16'hFFFD, 16'hFFEB, 1'b0, 1'b0, 1'b1, 16'd0, lat);
        repeat (4) @(negedge clk);
        check("idle_hold_result", 32'(result), 32'(16'hFFEB));
        run_op(16'd0, 16'd5, 16'd0, 1'b0, 1'b0, 1'b1, 16'hFFEB, lat);
        run_op(16'hFFFB, 16'hFFFB, 16'd25, 1'b0, 1'b0, 1'b0, 16'd0, lat);
        @(negedge clk);

        // Reset mid-RUN: outputs clear at once and the operation never completes.
        start = 1'b1;
        a     = 16'd7;
        b     = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_reset", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("async_reset_busy",   32'(busy),   32'd0);
        check("async_reset_done",   32'(done),   32'd0);
        check("async_reset_result", 32'(result), 32'd0);
        check("async_reset_ovf",    32'(ovf),    32'd0);
        prev = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("no_done_after_reset", 32'(done_cnt), 32'(prev));

        run_op(16'd7, 16'd3, 16'd21, 1'b0, 1'b0, 1'b0, 16'd0, lat);
        @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
